modular_multiplier: RTL and testbench

Pipelined Barrett modular multiplier: computes (a * b) mod Q for 30-bit residues 0 <= a, b < Q, with Q chosen from the project's 13-entry NTT prime table by `mod_index`. It is the twiddle-multiply stage of the NTT butterfly. Its output feeds the two-cycle modular adder and subtractor stages directly. It accepts one operand pair per cycle with a valid bit and has a fixed latency of 4 cycles.

---
 rtl/modular_multiplier.sv | 71 +++++++
 tb/tb_modular_multiplier.sv | 125 ++++++++++++
 2 files changed

// File: rtl/modular_multiplier.sv
// modular_multiplier: 4-stage pipelined Barrett (a*b) mod Q, Q chosen from the NTT prime table by mod_index
module modular_multiplier #(
    parameter int mod_index = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [29:0] a,
    input  logic [29:0] b,
    output logic        out_valid,
    output logic [29:0] c
);
    function automatic logic [63:0] q_sel(input int i);
        case (i)
            0:       return 64'd1063321601;
            1:       return 64'd1063452673;
            2:       return 64'd1064697857;
            3:       return 64'd1065484289;
            4:       return 64'd1065811969;
            5:       return 64'd1068236801;
            6:       return 64'd1068433409;
            7:       return 64'd1068564481;
            8:       return 64'd1069219841;
            9:       return 64'd1070727169;
            10:      return 64'd1071513601;
            11:      return 64'd1072496641;
            default: return 64'd1073479681;
        endcase
    endfunction
    localparam logic [63:0] q_full = q_sel(mod_index);
    localparam logic [63:0] mu_full = (64'd1 << 60) / q_full;
    localparam logic [30:0] mu = 31'(mu_full);
    localparam logic [31:0] q1 = 32'(q_full);
    localparam logic [31:0] q2 = 32'(q_full * 64'd2);
    logic [59:0] t1, t2;
    logic [30:0] qh;
    logic [31:0] r;
    logic        v1, v2, v3;
    logic [61:0] qh_full;
    logic [31:0] qq, d1, d2;
    // qh underestimates floor(t/Q) by at most 2, so r < 3Q and only low 32 bits matter
    always_comb begin
        qh_full = {31'b0, t1[59:29]} * {31'b0, mu};
        qq = {1'b0, qh} * q1;
        d1 = r - q1;
        d2 = r - q2;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1 <= '0;
            t2 <= '0;
            qh <= '0;
            r <= '0;
            c <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            t1 <= {30'b0, a} * {30'b0, b};
            v1 <= in_valid;
            qh <= qh_full[61:31];
            t2 <= t1;
            v2 <= v1;
            r <= t2[31:0] - qq;
            v3 <= v2;
            c <= r >= q2 ? d2[29:0] : r >= q1 ? d1[29:0] : r[29:0];
            out_valid <= v3;
        end
    end
endmodule

// File: tb/tb_modular_multiplier.sv
// tb_modular_multiplier: one DUT per prime, random/directed stimulus against a timestamped scoreboard
module tb_modular_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [12:0][29:0] a_v, b_v;
    logic [29:0] c_v [13];
    logic ov [13];
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    typedef struct packed {
        logic [31:0] stamp;
        logic v;
        logic [12:0][29:0] c;
    } exp_t;
    exp_t sb [$];
    exp_t e;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    for (genvar g = 0; g < 13; g++) begin : gen_dut
        modular_multiplier #(.mod_index(g)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
            .a(a_v[g]), .b(b_v[g]), .out_valid(ov[g]), .c(c_v[g])
        );
    end
    function automatic longint q_of(input int i);
        longint qs [13] = '{1063321601, 1063452673, 1064697857, 1065484289, 1065811969,
                            1068236801, 1068433409, 1068564481, 1069219841, 1070727169,
                            1071513601, 1072496641, 1073479681};
        return qs[i];
    endfunction
    // expected result is due on the negedge after the 4th clock edge following this drive
    task automatic step(input logic v);
        exp_t x;
        in_valid = v;
        x.stamp = 32'(cyc + 4);
        x.v = v;
        for (int i = 0; i < 13; i++)
            x.c[i] = 30'((longint'(a_v[i]) * longint'(b_v[i])) % q_of(i));
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask
    task automatic set_rand();
        for (int i = 0; i < 13; i++) begin
            a_v[i] = 30'(longint'($urandom) % q_of(i));
            b_v[i] = 30'(longint'($urandom) % q_of(i));
        end
    endtask
    task automatic set_all(input longint av, input longint bv, input bit minus_one);
        for (int i = 0; i < 13; i++) begin
            a_v[i] = minus_one ? 30'(q_of(i) - 1) : 30'(av);
            b_v[i] = minus_one ? 30'(q_of(i) - 1) : 30'(bv);
        end
    endtask
    task automatic check_idle(input string tag);
        for (int i = 0; i < 13; i++) begin
            n_vec++;
            if (ov[i] !== 1'b0 || c_v[i] !== 30'd0) begin
                n_bad++;
                $display("FAIL %s idx=%0d out_valid=%b c=%0d required out_valid=0 c=0", tag, i, ov[i], c_v[i]);
            end
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            e = '0;
            if (sb.size() > 0 && sb[0].stamp < 32'(cyc)) begin
                n_vec++;
                n_bad++;
                $display("FAIL stale expectation stamp=%0d cycle=%0d", sb[0].stamp, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].stamp == 32'(cyc)) e = sb.pop_front();
            for (int i = 0; i < 13; i++) begin
                n_vec++;
                if (ov[i] !== e.v) begin
                    n_bad++;
                    $display("FAIL out_valid idx=%0d cycle=%0d got=%b required=%b", i, cyc, ov[i], e.v);
                end else if (e.v && c_v[i] !== e.c[i]) begin
                    n_bad++;
                    $display("FAIL result idx=%0d cycle=%0d a=%0d b=%0d got=%0d required=%0d",
                             i, cyc, a_v[i], b_v[i], c_v[i], e.c[i]);
                end
            end
        end
    end
    initial begin
        a_v = '0;
        b_v = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst_n = 1'b1;
        set_all(0, 123456, 0); step(1);
        set_all(1, 0, 0);
        for (int i = 0; i < 13; i++) b_v[i] = 30'(q_of(i) - 1);
        step(1);
        step(0);
        set_all(0, 0, 1); step(1);
        set_all(32768, 32768, 0); step(1);
        step(0);
        step(0);
        for (int n = 0; n < 1000; n++) begin set_rand(); step(1); end
        for (int n = 0; n < 1000; n++) begin set_rand(); step(1'($urandom_range(0, 1))); end
        repeat (6) step(0);
        for (int n = 0; n < 3; n++) begin set_rand(); step(1); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("reset_midflight");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) step(0);
        set_all(0, 0, 1); step(1);
        for (int n = 0; n < 50; n++) begin set_rand(); step(1); end
        repeat (6) step(0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
